// File: rtl/lfsr_step_ctrl_pkg.sv
// Shared definitions for the LFSR step controller: register width, feedback
// taps, the substitute for an all-zero seed, the per-cycle action type and
// the two pure helper functions used by the q register.
package lfsr_step_ctrl_pkg;

  localparam int LFSR_W = 8;

  // Feedback taps for x^8+x^4+x^3+x^2+1 expressed on the shift register bits
  // q[4], q[3], q[2] and q[0]; the parity of these bits enters at the top.
  localparam logic [LFSR_W-1:0] TAP_MASK = 8'b0001_1101;

  // An all-zero register never leaves zero, so a zero seed is replaced.
  localparam logic [LFSR_W-1:0] SEED_ZERO_SUB = 8'h01;

  // What the q register does in a given cycle, already priority-resolved.
  typedef enum logic [1:0] {
    ACT_NONE = 2'd0,
    ACT_STEP = 2'd1,
    ACT_LOAD = 2'd2
  } action_e;

  // One Fibonacci shift: parity of the tapped bits becomes the new MSB.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    return {^(cur & TAP_MASK), cur[LFSR_W-1:1]};
  endfunction

  // Map a switch value to a legal seed so the lockup state is unreachable.
  function automatic logic [LFSR_W-1:0] seed_sanitize(input logic [LFSR_W-1:0] sw);
    return (sw == '0) ? SEED_ZERO_SUB : sw;
  endfunction

endpackage

// File: rtl/lfsr_step_ctrl_debounce.sv
// Key conditioner: two-flop synchronizer, counter-based debounce and a
// single-cycle pulse on each accepted rising level. Releases are debounced
// the same way but produce no pulse.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p1;
  logic             sync_p2;
  logic             stable;
  logic             stable_d;
  logic [CNT_W-1:0] cnt;

  // Bring the raw key into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p1 <= 1'b0;
      sync_p2 <= 1'b0;
    end else begin
      sync_p1 <= raw;
      sync_p2 <= sync_p1;
    end
  end

  // Accept a new level only after it has differed from the stable one for
  // DEBOUNCE_CYCLES consecutive cycles; any return to stable restarts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= 1'b0;
      cnt    <= '0;
    end else if (sync_p2 == stable) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      stable <= sync_p2;
      cnt    <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Delayed copy of the accepted level for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_d <= 1'b0;
    end else begin
      stable_d <= stable;
    end
  end

  assign press = stable & ~stable_d;

endmodule

// File: rtl/lfsr_step_ctrl.sv
// 8-bit Fibonacci LFSR stepped by a debounced key, an auto-run prescaler
// tick, or reloaded from the seed switches by a second debounced key.
// The two nibbles go straight to the board's hex digit decoders.
module lfsr_step_ctrl
  import lfsr_step_ctrl_pkg::*;
#(
  parameter int                DEBOUNCE_CYCLES = 20,
  parameter int                AUTO_DIV        = 4,
  parameter logic [LFSR_W-1:0] SEED            = 8'h01
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_step,
  input  logic              btn_load,
  input  logic [LFSR_W-1:0] sw_seed,
  input  logic              sw_auto,
  output logic [LFSR_W-1:0] q,
  output logic [3:0]        hex_lo,
  output logic [3:0]        hex_hi,
  output logic              step_pulse,
  output logic [7:0]        step_cnt
);

  localparam int PRE_W = $clog2(AUTO_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(AUTO_DIV - 1);

  logic             step_press;
  logic             load_press;
  logic             auto_p1;
  logic             auto_p2;
  logic [PRE_W-1:0] pre;
  logic             tick;
  action_e          action;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_key (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (btn_step),
    .press(step_press)
  );

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_load_key (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (btn_load),
    .press(load_press)
  );

  // The auto switch is a slow level, so it is synchronized but not debounced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auto_p1 <= 1'b0;
      auto_p2 <= 1'b0;
    end else begin
      auto_p1 <= sw_auto;
      auto_p2 <= auto_p1;
    end
  end

  // Free-running divider while auto is on, parked at zero while it is off;
  // manual presses and loads deliberately leave its phase alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
    end else if (!auto_p2) begin
      pre <= '0;
    end else if (pre == PRE_LAST) begin
      pre <= '0;
    end else begin
      pre <= pre + PRE_W'(1);
    end
  end

  assign tick = auto_p2 && (pre == PRE_LAST);

  // Resolve the cycle's action: a load wins, and a press coinciding with a
  // tick still yields a single step.
  always_comb begin
    action = ACT_NONE;
    if (load_press) begin
      action = ACT_LOAD;
    end else if (step_press || tick) begin
      action = ACT_STEP;
    end
  end

  // LFSR state, step counter and the pulse marking the first cycle of a new value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q          <= SEED;
      step_cnt   <= '0;
      step_pulse <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      unique case (action)
        ACT_LOAD: begin
          q        <= seed_sanitize(sw_seed);
          step_cnt <= '0;
        end
        ACT_STEP: begin
          q          <= lfsr_next(q);
          step_cnt   <= step_cnt + 8'd1;
          step_pulse <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign hex_lo = q[3:0];
  assign hex_hi = q[7:4];

endmodule

// File: tb/tb_lfsr_step_ctrl.sv
// Self-checking bench for lfsr_step_ctrl with a sequence-level reference model.
module tb_lfsr_step_ctrl;

  localparam int DC = 20;
  localparam int AD = 4;
  localparam logic [7:0] SEED = 8'h01;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_step = 1'b0;
  logic       btn_load = 1'b0;
  logic       sw_auto = 1'b0;
  logic [7:0] sw_seed = 8'h00;
  logic [7:0] q;
  logic [3:0] hex_lo;
  logic [3:0] hex_hi;
  logic       step_pulse;
  logic [7:0] step_cnt;

  always #5 clk = ~clk;

  lfsr_step_ctrl #(
    .DEBOUNCE_CYCLES(DC),
    .AUTO_DIV       (AD),
    .SEED           (SEED)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_step  (btn_step),
    .btn_load  (btn_load),
    .sw_seed   (sw_seed),
    .sw_auto   (sw_auto),
    .q         (q),
    .hex_lo    (hex_lo),
    .hex_hi    (hex_hi),
    .step_pulse(step_pulse),
    .step_cnt  (step_cnt)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // pulse observation (updated only inside tick)
  int   cyc = 0;
  int   pulses = 0;
  int   wide = 0;
  int   last_pc = -1;
  int   last_gap = 0;
  logic prev_pulse = 1'b0;

  // reference model state
  logic [7:0] m_q = SEED;
  int         m_cnt = 0;
  int         m_pulses = 0;

  // Next value from the polynomial: new MSB = parity of bits 4,3,2,0.
  function automatic logic [7:0] ref_next(input logic [7:0] v);
    int iv;
    int fb;
    iv = int'(v);
    fb = ((iv >> 4) + (iv >> 3) + (iv >> 2) + iv) % 2;
    return 8'((iv / 2) + fb * 128);
  endfunction

  task automatic model_step();
    m_q = ref_next(m_q);
    m_cnt = (m_cnt + 1) % 256;
    m_pulses++;
  endtask

  task automatic model_load(input logic [7:0] s);
    m_q = (s == 8'h00) ? 8'h01 : s;
    m_cnt = 0;
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (step_pulse === 1'b1) begin
      pulses++;
      if (prev_pulse) wide++;
      if (last_pc >= 0) last_gap = cyc - last_pc;
      last_pc = cyc;
    end
    prev_pulse = step_pulse;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    m_q = SEED;
    m_cnt = 0;
  endtask

  task automatic key_action(input bit is_load, input int len);
    if (is_load) btn_load = 1'b1; else btn_step = 1'b1;
    repeat (len) tick();
    btn_load = 1'b0;
    btn_step = 1'b0;
    repeat (DC + 5) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    n_cmp++; if (q !== SEED) begin n_fail++; $display("FAIL reset_q: got %h expected %h", q, SEED); end
    n_cmp++; if (step_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", step_cnt); end
    n_cmp++; if (step_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_pulse: got %b expected 0", step_pulse); end
    n_cmp++; if ({hex_hi, hex_lo} !== SEED) begin n_fail++; $display("FAIL reset_hex: got %h expected %h", {hex_hi, hex_lo}, SEED); end
    rst_n = 1'b1;
    repeat (10) tick();
    n_cmp++; if (q !== SEED || pulses != 0) begin n_fail++; $display("FAIL reset_idle: got q=%h pulses=%0d expected q=%h pulses=0", q, pulses, SEED); end
  endtask

  task automatic test_steps();
    logic [7:0] exp_tab [5];
    int p0;
    exp_tab = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h88};
    do_reset();
    p0 = pulses;
    for (int i = 0; i < 5; i++) begin
      key_action(1'b0, DC + 4);
      model_step();
      n_cmp++; if (q !== exp_tab[i]) begin n_fail++; $display("FAIL step_q[%0d]: got %h expected %h", i, q, exp_tab[i]); end
      n_cmp++; if (step_cnt !== 8'(i + 1)) begin n_fail++; $display("FAIL step_cnt[%0d]: got %0d expected %0d", i, step_cnt, i + 1); end
    end
    n_cmp++; if (pulses - p0 != 5) begin n_fail++; $display("FAIL step_pulses: got %0d expected 5", pulses - p0); end
    n_cmp++; if (wide != 0) begin n_fail++; $display("FAIL step_pulse_width: got %0d wide pulses expected 0", wide); end
  endtask

  task automatic test_latency();
    logic [7:0] old;
    int early;
    int p0;
    old = m_q;
    early = 0;
    btn_step = 1'b1;  // set just before edge 0
    for (int k = 0; k < DC + 2; k++) begin
      tick();
      if (q !== old) early++;
    end
    tick();  // sample after edge DC+2
    n_cmp++; if (early != 0) begin n_fail++; $display("FAIL latency_early: got %0d early samples expected 0", early); end
    n_cmp++; if (q !== ref_next(old)) begin n_fail++; $display("FAIL latency_q: got %h expected %h", q, ref_next(old)); end
    n_cmp++; if (step_pulse !== 1'b1) begin n_fail++; $display("FAIL latency_pulse: got %b expected 1", step_pulse); end
    model_step();
    btn_step = 1'b0;
    repeat (DC + 5) tick();
    // 15-cycle glitch and the exact acceptance boundary
    p0 = pulses;
    key_action(1'b0, 15);
    n_cmp++; if (q !== m_q || pulses != p0) begin n_fail++; $display("FAIL glitch15: got q=%h pulses=%0d expected q=%h pulses=%0d", q, pulses, m_q, p0); end
    key_action(1'b0, DC - 1);
    n_cmp++; if (q !== m_q || pulses != p0) begin n_fail++; $display("FAIL glitch_dc_minus1: got q=%h pulses=%0d expected q=%h pulses=%0d", q, pulses, m_q, p0); end
    key_action(1'b0, DC);
    model_step();
    n_cmp++; if (q !== m_q || pulses != p0 + 1) begin n_fail++; $display("FAIL press_dc_exact: got q=%h pulses=%0d expected q=%h pulses=%0d", q, pulses, m_q, p0 + 1); end
  endtask

  task automatic test_load();
    int p0;
    sw_seed = 8'hA5;
    key_action(1'b1, DC + 4);
    model_load(8'hA5);
    n_cmp++; if (q !== 8'hA5) begin n_fail++; $display("FAIL load_a5_q: got %h expected a5", q); end
    n_cmp++; if (step_cnt !== 8'd0) begin n_fail++; $display("FAIL load_a5_cnt: got %0d expected 0", step_cnt); end
    sw_seed = 8'h00;
    key_action(1'b1, DC + 4);
    model_load(8'h00);
    n_cmp++; if (q !== 8'h01) begin n_fail++; $display("FAIL load_zero_q: got %h expected 01", q); end
    key_action(1'b0, DC + 4);
    model_step();
    sw_seed = 8'h3C;
    p0 = pulses;
    btn_load = 1'b1;
    btn_step = 1'b1;
    key_action(1'b1, DC + 4);
    model_load(8'h3C);
    n_cmp++; if (q !== 8'h3C) begin n_fail++; $display("FAIL load_and_step_q: got %h expected 3c", q); end
    n_cmp++; if (step_cnt !== 8'd0) begin n_fail++; $display("FAIL load_and_step_cnt: got %0d expected 0", step_cnt); end
    n_cmp++; if (pulses != p0) begin n_fail++; $display("FAIL load_and_step_pulse: got %0d pulses expected %0d", pulses - p0, 0); end
  endtask

  task automatic test_random();
    int choice;
    logic [7:0] s;
    for (int it = 0; it < 16; it++) begin
      choice = int'($urandom_range(0, 3));
      case (choice)
        0: begin key_action(1'b0, int'($urandom_range(DC + 1, 2 * DC))); model_step(); end
        1: key_action(1'b0, int'($urandom_range(1, DC - 2)));
        2: begin
          s = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
          sw_seed = s;
          key_action(1'b1, int'($urandom_range(DC + 1, 2 * DC)));
          model_load(s);
        end
        default: key_action(1'b1, int'($urandom_range(1, DC - 2)));
      endcase
      n_cmp++; if (q !== m_q || step_cnt !== 8'(m_cnt) || pulses != m_pulses) begin
        n_fail++;
        $display("FAIL random[%0d] op%0d: got q=%h cnt=%0d pulses=%0d expected q=%h cnt=%0d pulses=%0d",
                 it, choice, q, step_cnt, pulses, m_q, m_cnt, m_pulses);
      end
    end
  endtask

  task automatic test_auto();
    logic [7:0] start;
    int steps, q_err, gap_err, budget, p0;
    start = m_q;
    steps = 0; q_err = 0; gap_err = 0;
    budget = 255 * AD + 40;
    sw_auto = 1'b1;
    while (steps < 255 && budget > 0) begin
      tick();
      budget--;
      if (step_pulse === 1'b1) begin
        steps++;
        model_step();
        if (q !== m_q) q_err++;
        if (steps > 1 && last_gap != AD) gap_err++;
        if (steps == 255) sw_auto = 1'b0;
      end
    end
    sw_auto = 1'b0;
    n_cmp++; if (steps != 255) begin n_fail++; $display("FAIL auto_steps: got %0d expected 255", steps); end
    n_cmp++; if (q_err != 0) begin n_fail++; $display("FAIL auto_seq: got %0d wrong values expected 0", q_err); end
    n_cmp++; if (gap_err != 0) begin n_fail++; $display("FAIL auto_period: got %0d bad gaps expected 0", gap_err); end
    n_cmp++; if (q !== start) begin n_fail++; $display("FAIL auto_period255: got %h expected %h", q, start); end
    n_cmp++; if (step_cnt !== 8'(m_cnt)) begin n_fail++; $display("FAIL auto_cnt: got %0d expected %0d", step_cnt, m_cnt); end
    p0 = pulses;
    repeat (DC) tick();
    n_cmp++; if (pulses != p0) begin n_fail++; $display("FAIL auto_off: got %0d extra pulses expected 0", pulses - p0); end
  endtask

  task automatic test_auto_manual();
    int budget, m, cnt, gap_err, p0;
    sw_auto = 1'b1;
    budget = 30;
    while (step_pulse !== 1'b1 && budget > 0) begin tick(); budget--; end
    n_cmp++; if (budget == 0) begin n_fail++; $display("FAIL auto_first_tick: got timeout expected a pulse"); end
    model_step();
    m = (AD - ((DC + 3) % AD)) % AD;
    repeat (m) tick();
    cnt = 0; gap_err = 0;
    btn_step = 1'b1;
    for (int j = 0; j < 10 * AD - m; j++) begin
      if (j == DC + 4) btn_step = 1'b0;
      tick();
      if (step_pulse === 1'b1) begin
        cnt++;
        model_step();
        if (last_gap != AD) gap_err++;
      end
    end
    sw_auto = 1'b0;
    btn_step = 1'b0;
    p0 = pulses;
    repeat (DC + 10) tick();
    n_cmp++; if (cnt != 10) begin n_fail++; $display("FAIL manual_on_tick_steps: got %0d expected 10", cnt); end
    n_cmp++; if (gap_err != 0) begin n_fail++; $display("FAIL manual_on_tick_phase: got %0d bad gaps expected 0", gap_err); end
    n_cmp++; if (q !== m_q || pulses != p0) begin n_fail++; $display("FAIL manual_on_tick_q: got q=%h extra=%0d expected q=%h extra=0", q, pulses - p0, m_q); end
  endtask

  task automatic test_reset_mid();
    int p0;
    if (m_q == SEED) begin key_action(1'b0, DC + 4); model_step(); end
    // mid-debounce
    btn_step = 1'b1;
    repeat (10) tick();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (q !== SEED || step_cnt !== 8'd0 || step_pulse !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_debounce: got q=%h cnt=%0d pulse=%b expected q=%h cnt=0 pulse=0", q, step_cnt, step_pulse, SEED);
    end
    btn_step = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    m_q = SEED; m_cnt = 0;
    p0 = pulses;
    repeat (DC + 10) tick();
    n_cmp++; if (pulses != p0 || q !== SEED) begin n_fail++; $display("FAIL rst_mid_debounce_after: got q=%h pulses=%0d expected q=%h pulses=%0d", q, pulses, SEED, p0); end
    // mid-auto
    sw_auto = 1'b1;
    repeat (13) tick();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (q !== SEED || step_cnt !== 8'd0 || step_pulse !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_auto: got q=%h cnt=%0d pulse=%b expected q=%h cnt=0 pulse=0", q, step_cnt, step_pulse, SEED);
    end
    sw_auto = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    p0 = pulses;
    repeat (DC + 10) tick();
    n_cmp++; if (pulses != p0 || q !== SEED || step_cnt !== 8'd0) begin
      n_fail++; $display("FAIL rst_mid_auto_after: got q=%h cnt=%0d pulses=%0d expected q=%h cnt=0 pulses=%0d", q, step_cnt, pulses, SEED, p0);
    end
  endtask

  initial begin
    test_reset();
    test_steps();
    test_latency();
    test_load();
    test_random();
    test_auto();
    test_auto_manual();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
